fp_div_result_stage: RTL and testbench
======================================

// Module: fp_div_result_stage
// PURPOSE
//  Pipelined output stage downstream of the combinational FP32 divider. Registers operands with the raw
//  quotient word, overrides it for IEEE-754 special cases and exponent over/underflow, raises exception
//  flags, and returns the final result to the ALU result bus over a valid/ready handshake.
// PARAMETERS
//  EXP_W   8               exponent field width
//  MAN_W   23              mantissa field width
//  BIAS    127             exponent bias
//  QNAN    32'h7FC0_0000   canonical quiet NaN returned for invalid operations
// PORTS
//  clk        in   1   clock, rising edge
//  rst_n      in   1   asynchronous active-low reset
//  in_valid   in   1   operands and raw quotient valid
//  in_ready   out  1   stage 1 can accept
//  op_x       in   32  dividend (FP32)
//  op_b       in   32  divisor (FP32)
//  raw_q      in   32  divider output for op_x/op_b, same cycle
//  out_valid  out  1   result valid
//  out_ready  in   1   consumer accepts result
//  result     out  32  final quotient (FP32)
//  out_flags  out  5   {NV,DZ,OF,UF,NX} for this result
//  flag_clr   in   1   clear sticky flags
//  sticky     out  5   OR of out_flags over accepted results since reset/clear
// BEHAVIOUR
//  - Reset (async, rst_n=0): s1_valid=s2_valid=0, out_valid=0, result=0, out_flags=0, sticky=0. Takes
//    effect mid-transfer; in-flight items are dropped.
//  - Two stages, latency 2 cycles from input handshake to out_valid when unstalled; 1 result/cycle.
//  - Advance: s2 loads when !s2_valid || out_ready. s1 loads when !s1_valid || s2 loads.
//    in_ready = !s1_valid || s2 loads (combinational). Items never reorder, drop or duplicate.
//  - Stage 1 (register + classify): captures op_x, op_b, raw_q; classifies each operand as ZERO, NORM,
//    INF or NAN. Denormal inputs count as ZERO (DAZ). Computes e = xe - be + BIAS - adj, signed
//    10-bit; adj=1 when x mantissa < b mantissa (quotient < 1.0).
//  - Stage 2 (select), first matching rule wins; sign s = xs ^ bs:
//    1. x or b NAN, 0/0, or INF/INF  -> QNAN, NV
//    2. x NORM, b ZERO               -> {s,8'hFF,0}, DZ
//    3. x INF (b not INF)            -> {s,8'hFF,0}
//    4. x ZERO, or b INF             -> {s,31'b0}
//    5. e >= 255                     -> {s,8'hFF,0}, OF|NX
//    6. e <= 0                       -> {s,31'b0}, UF|NX (flush-to-zero, no denormals)
//    7. otherwise                    -> raw_q unchanged; NX=0 (divider truncates, NX not tracked)
//  - result/out_flags hold stable while out_valid && !out_ready.
//  - sticky: on (out_valid && out_ready) ORs out_flags in. flag_clr clears; same-cycle clear and accept
//    -> sticky = out_flags of accepted item (set wins).
// STRUCTURE
//  - Package fp_div_pkg: EXP_W, MAN_W, BIAS, QNAN, flag bit indices, typedef enum fp_class_t
//    {FP_ZERO,FP_NORM,FP_INF,FP_NAN}, FP32 field struct.
//  - Sub-module fp_classify (32-bit in -> fp_class_t), instantiated for op_x and op_b in stage 1.
//  - Special-case select and sticky logic stay in this module.
// TESTING
//  1. 0x40C00000/0x40000000, raw_q=0x40400000, out_ready=1 -> result 0x40400000, flags 0, 2 cycles.
//  2. 0x3F800000/0x00000000 -> 0x7F800000, DZ; then 0x80000000/0x00000000 -> 0x7FC00000, NV; sticky
//     = NV|DZ; flag_clr pulse -> sticky 0.
//  3. 0x7F000000/0x00800000 (e=380) -> 0x7F800000, OF|NX; 0x00800000/0x7F000000 (e=-126) -> 0x00000000,
//     UF|NX.
//  4. Backpressure: stream 4 items, out_ready low 3 cycles after first -> in_ready low while both stages
//     full, result held stable, all 4 emerge in order, none lost.
//  5. 0xFF800000/0x40000000 -> 0xFF800000; 0x40000000/0x7F800000 -> 0x00000000; 0x7FC00001 as b -> 0x7FC00000, NV.
//  6. Assert rst_n low with both stages full -> out_valid 0, sticky 0 immediately; first post-reset
//     item emerges after 2 cycles.

Source files
------------

// File: rtl/fp_div_pkg.sv
// Shared FP32 definitions for the divider result stage: field layout, operand classes,
// canonical NaN and exception-flag bit positions.
package fp_div_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int BIAS  = 127;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  // Bit positions within the {NV,DZ,OF,UF,NX} flag vector
  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  typedef enum logic [1:0] {
    FP_ZERO,
    FP_NORM,
    FP_INF,
    FP_NAN
  } fp_class_t;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } fp32_t;

endpackage

// File: rtl/fp_classify.sv
// Classifies one FP32 operand; denormals are treated as zero (DAZ).
module fp_classify
  import fp_div_pkg::*;
(
  input  logic [31:0] value,
  output fp_class_t   cls,
  output logic        neg
);

  fp32_t f;

  assign f   = value;
  assign neg = f.sign;

  always_comb begin
    cls = FP_NORM;
    if (f.exp == '0) begin
      cls = FP_ZERO;
    end else if (f.exp == '1) begin
      cls = (f.man == '0) ? FP_INF : FP_NAN;
    end
  end

endmodule

// File: rtl/fp_div_result_stage.sv
// Two-stage output pipeline for the FP32 divider: registers and classifies operands, then
// overrides the raw quotient for special cases and exponent range, with sticky flags.
module fp_div_result_stage
  import fp_div_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] op_x,
  input  logic [31:0] op_b,
  input  logic [31:0] raw_q,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic [4:0]  out_flags,
  input  logic        flag_clr,
  output logic [4:0]  sticky
);

  function automatic logic [36:0] select_result(input fp_class_t cx, input fp_class_t cb,
                                                input logic s, input logic signed [9:0] e,
                                                input logic [31:0] q);
    logic [4:0]  f;
    logic [31:0] r;
    f = '0;
    r = q;
    if (cx == FP_NAN || cb == FP_NAN || (cx == FP_ZERO && cb == FP_ZERO) ||
        (cx == FP_INF && cb == FP_INF)) begin
      r = QNAN;
      f[FLAG_NV] = 1'b1;
    end else if (cx == FP_NORM && cb == FP_ZERO) begin
      r = {s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      f[FLAG_DZ] = 1'b1;
    end else if (cx == FP_INF) begin
      r = {s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (cx == FP_ZERO || cb == FP_INF) begin
      r = {s, 31'h0};
    end else if (e >= 10'sd255) begin
      r = {s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      f[FLAG_OF] = 1'b1;
      f[FLAG_NX] = 1'b1;
    end else if (e <= 10'sd0) begin
      // Flush to zero: the divider path never produces denormals
      r = {s, 31'h0};
      f[FLAG_UF] = 1'b1;
      f[FLAG_NX] = 1'b1;
    end
    return {f, r};
  endfunction

  logic             vld_p1, vld_p2;
  logic             load_p1, load_p2;
  fp_class_t        cls_x, cls_b;
  logic             neg_x, neg_b;
  logic             adj;
  logic signed [9:0] e_in;

  fp_class_t         cls_x_p1, cls_b_p1;
  logic              sign_p1;
  logic signed [9:0] e_p1;
  logic [31:0]       raw_q_p1;
  logic [36:0]       sel_p1;

  assign load_p2  = !vld_p2 || out_ready;
  assign load_p1  = !vld_p1 || load_p2;
  assign in_ready = load_p1;

  fp_classify u_cls_x (.value(op_x), .cls(cls_x), .neg(neg_x));
  fp_classify u_cls_b (.value(op_b), .cls(cls_b), .neg(neg_b));

  // Quotient mantissa below 1.0 costs one exponent step
  assign adj  = op_x[MAN_W-1:0] < op_b[MAN_W-1:0];
  assign e_in = 10'(op_x[30:MAN_W]) - 10'(op_b[30:MAN_W]) + 10'(BIAS) - 10'(adj);

  // Stage 1: capture and classify
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
    end else if (load_p1) begin
      vld_p1 <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (load_p1 && in_valid) begin
      cls_x_p1 <= cls_x;
      cls_b_p1 <= cls_b;
      sign_p1  <= neg_x ^ neg_b;
      e_p1     <= e_in;
      raw_q_p1 <= raw_q;
    end
  end

  assign sel_p1 = select_result(cls_x_p1, cls_b_p1, sign_p1, e_p1, raw_q_p1);

  // Stage 2: special-case select, output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2    <= 1'b0;
      result    <= '0;
      out_flags <= '0;
    end else if (load_p2) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        {out_flags, result} <= sel_p1;
      end
    end
  end

  assign out_valid = vld_p2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky <= '0;
    end else if (out_valid && out_ready) begin
      sticky <= flag_clr ? out_flags : (sticky | out_flags);
    end else if (flag_clr) begin
      sticky <= '0;
    end
  end

endmodule

// File: tb/tb_fp_div_result_stage.sv
// Scoreboard bench for fp_div_result_stage: directed special cases, backpressure, reset and
// randomized traffic against a behavioural model of the result rules.
module tb_fp_div_result_stage;

  localparam logic [4:0] NV = 5'b10000;
  localparam logic [4:0] DZ = 5'b01000;
  localparam logic [4:0] OF = 5'b00100;
  localparam logic [4:0] UF = 5'b00010;
  localparam logic [4:0] NX = 5'b00001;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] op_x = '0, op_b = '0, raw_q = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic [4:0]  out_flags;
  logic        flag_clr = 1'b0;
  logic [4:0]  sticky;

  int checks = 0;
  int passed = 0;
  logic [36:0] sb[$];
  logic [4:0]  exp_sticky = '0;
  bit          rand_bp = 0;

  fp_div_result_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_x(op_x), .op_b(op_b), .raw_q(raw_q), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .out_flags(out_flags), .flag_clr(flag_clr), .sticky(sticky)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [36:0] act, input logic [36:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference: result and flags straight from the IEEE special-case rules and exponent range
  function automatic logic [36:0] model(input logic [31:0] x, input logic [31:0] b,
                                        input logic [31:0] q);
    int xe, be, xm, bm, e;
    bit xz, xi, xn, bz, bi, bn, s;
    xe = int'(x[30:23]); be = int'(b[30:23]);
    xm = int'(x[22:0]);  bm = int'(b[22:0]);
    xz = (xe == 0); xi = (xe == 255 && xm == 0); xn = (xe == 255 && xm != 0);
    bz = (be == 0); bi = (be == 255 && bm == 0); bn = (be == 255 && bm != 0);
    s  = x[31] ^ b[31];
    e  = xe - be + 127 - ((xm < bm) ? 1 : 0);
    if (xn || bn || (xz && bz) || (xi && bi)) return {NV, 32'h7FC00000};
    if (!xz && !xi && bz) return {DZ, s, 31'h7F800000};
    if (xi) return {5'b0, s, 31'h7F800000};
    if (xz || bi) return {5'b0, s, 31'h0};
    if (e >= 255) return {OF | NX, s, 31'h7F800000};
    if (e <= 0) return {UF | NX, s, 31'h0};
    return {5'b0, q};
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [31:0] v;
    v = $urandom;
    case ($urandom % 8)
      0: v[30:0] = 31'h0;
      1: v[30:0] = 31'h7F800000;
      2: begin v[30:23] = 8'hFF; v[22] = 1'b1; end
      3: v[30:23] = 8'h00;
      default: v[30:23] = 8'($urandom_range(1, 254));
    endcase
    return v;
  endfunction

  task automatic send(input logic [31:0] x, input logic [31:0] b, input logic [31:0] q);
    bit acc;
    int n;
    acc = 0;
    n = 0;
    op_x = x; op_b = b; raw_q = q; in_valid = 1'b1;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (acc) sb.push_back(model(x, b, q));
    else check("send_timeout", 37'd0, 37'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_empty", 37'(sb.size()), 37'd0);
  endtask

  // Monitor: compare every presented output against the scoreboard head; track sticky
  always @(negedge clk) begin
    logic [36:0] head;
    logic [4:0]  nxt;
    if (rst_n) begin
      check("sticky", {32'b0, sticky}, {32'b0, exp_sticky});
      nxt = exp_sticky;
      if (flag_clr) nxt = '0;
      if (out_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_output", {out_flags, result}, 37'h0);
        end else begin
          head = sb[0];
          check("result", {5'b0, result}, {5'b0, head[31:0]});
          check("out_flags", {32'b0, out_flags}, {32'b0, head[36:32]});
          if (out_ready) begin
            void'(sb.pop_front());
            nxt = flag_clr ? head[36:32] : (exp_sticky | head[36:32]);
          end
        end
      end
      exp_sticky = nxt;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_bp) begin
        out_ready = ($urandom % 4) != 0;
        flag_clr  = ($urandom % 16) == 0;
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {36'b0, out_valid}, 37'd0);
    check("rst_result", {5'b0, result}, 37'd0);
    check("rst_flags", {32'b0, out_flags}, 37'd0);
    check("rst_sticky", {32'b0, sticky}, 37'd0);
    check("rst_in_ready", {36'b0, in_ready}, 37'd1);
    rst_n = 1'b1;

    // Basic quotient with latency
    send(32'h40C00000, 32'h40000000, 32'h40400000);
    check("lat1_not_yet", {36'b0, out_valid}, 37'd0);
    @(posedge clk); #1;
    check("lat2_valid", {36'b0, out_valid}, 37'd1);
    drain();

    // Divide by zero, 0/0, sticky, clear
    send(32'h3F800000, 32'h00000000, 32'h12345678);
    send(32'h80000000, 32'h00000000, 32'h12345678);
    drain();
    check("sticky_nv_dz", {32'b0, sticky}, {32'b0, NV | DZ});
    flag_clr = 1'b1;
    @(posedge clk); #1;
    flag_clr = 1'b0;
    check("sticky_cleared", {32'b0, sticky}, 37'd0);

    // Exponent overflow / underflow, infinities, NaN operand
    send(32'h7F000000, 32'h00800000, 32'h55555555);
    send(32'h00800000, 32'h7F000000, 32'h55555555);
    send(32'hFF800000, 32'h40000000, 32'h55555555);
    send(32'h40000000, 32'h7F800000, 32'h55555555);
    send(32'h3F800000, 32'h7FC00001, 32'h55555555);
    drain();

    // Backpressure: fill both stages, hold, then release
    out_ready = 1'b0;
    send(32'h40800000, 32'h40000000, 32'h40000000);
    send(32'h41000000, 32'h40000000, 32'h40800000);
    op_x = 32'h41800000; op_b = 32'h40000000; raw_q = 32'h41000000; in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("bp_in_ready_low", {36'b0, in_ready}, 37'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(32'h41800000, 32'h40000000, 32'h41000000);
    send(32'h42000000, 32'h40000000, 32'h41800000);
    drain();

    // Randomized traffic with backpressure and clears
    rand_bp = 1;
    for (int i = 0; i < 400; i++) send(rand_fp(), rand_fp(), $urandom);
    rand_bp = 0;
    @(posedge clk); #2;
    out_ready = 1'b1;
    flag_clr  = 1'b0;
    drain();

    // Reset with both stages full
    send(32'h3F800000, 32'h00000000, 32'h0);
    drain();
    out_ready = 1'b0;
    send(32'h40C00000, 32'h40000000, 32'h40400000);
    send(32'h40C00000, 32'h40000000, 32'h40400000);
    @(negedge clk);
    check("full_in_ready_low", {36'b0, in_ready}, 37'd0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", {36'b0, out_valid}, 37'd0);
    check("mid_rst_sticky", {32'b0, sticky}, 37'd0);
    check("mid_rst_result", {5'b0, result}, 37'd0);
    sb.delete();
    exp_sticky = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    send(32'h40C00000, 32'h40000000, 32'h40400000);
    check("post_rst_lat1", {36'b0, out_valid}, 37'd0);
    @(posedge clk); #1;
    check("post_rst_lat2", {36'b0, out_valid}, 37'd1);
    drain();

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
